// File: rtl/dnn_eval_pkg.sv
// Shared helpers for DNN output evaluation: threshold constant, block length, saturating count.
// Pure constants/functions; no latency or flow control of its own.
package dnn_eval_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        REPORT  = 2'd2
    } sb_state_t;

    // Fixed-point 0.5 for an activation with fb fractional bits.
    function automatic logic [63:0] half_of(input int fb);
        return 64'd1 << (fb - 1);
    endfunction

    // Clocks per training-case block: data cycles plus two pipeline-fill cycles.
    function automatic int cpc_of(input int n0, input int fo0, input int z0);
        return (n0 * fo0) / z0 + 2;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        if (en && (v != 32'hFFFF_FFFF))
            return v + 32'd1;
        return v;
    endfunction

endpackage

// File: rtl/rolling_window_count.sv
// Counts ones among the last `window` inputs via history shift register and incremental popcount.
// Count updates 1 clock after en; no backpressure, one input per enabled clock.
module rolling_window_count #(
    parameter int window = 100,
    localparam int cw = $clog2(window + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          bit_in,
    output logic [cw-1:0] count
);

    logic [window-1:0] hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            hist  <= '0;
            count <= '0;
        end else if (en) begin
            // Oldest bit is still 0 until the window has filled, so the count never goes negative.
            count <= count + cw'(bit_in) - cw'(hist[window-1]);
            hist  <= {hist[window-2:0], bit_in};
        end
    end

endmodule

// File: rtl/dnn_output_scoreboard.sv
// Assembles per-case prediction/ideal vectors, judges each case, keeps case/error/window counters.
// Results and case_done 1 clock after the last sample; no backpressure, one sample per clock.
module dnn_output_scoreboard
    import dnn_eval_pkg::*;
#(
    parameter int width     = 32,
    parameter int frac_bits = 21,
    parameter int cpc       = 18,
    parameter int n_out     = 16,
    parameter int window    = 100,
    localparam int iw = $clog2(cpc),
    localparam int rw = $clog2(window + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [iw-1:0]    cycle_index,
    input  logic [width-1:0] act,
    input  logic             a_out,
    input  logic             y_out,
    output logic             case_done,
    output logic             case_correct,
    output logic             case_error,
    output logic [n_out-1:0] pred,
    output logic [n_out-1:0] ideal,
    output logic [31:0]      num_cases,
    output logic [31:0]      total_errors,
    output logic [rw-1:0]    recent_correct
);

    localparam logic [iw-1:0]    first_idx = iw'(2);
    localparam logic [iw-1:0]    last_idx  = iw'(cpc - 1);
    localparam logic [iw-1:0]    last_k    = iw'(n_out - 1);
    localparam logic [width-1:0] half      = width'(half_of(frac_bits));

    sb_state_t        state, state_nx;
    logic [iw-1:0]    exp_k;
    logic             mism_acc, err_acc;
    logic [n_out-1:0] pred_acc, ideal_acc;

    logic             accept, start, take, last;
    logic [iw-1:0]    k;
    logic             decision, undecided, mism_s;
    logic             mism_nx, err_nx;
    logic [n_out-1:0] pred_nx, ideal_nx;

    always_comb begin
        accept    = (cycle_index >= first_idx) && (cycle_index <= last_idx);
        k         = cycle_index - first_idx;
        decision  = !act[width-1] && (act > half);
        undecided = !act[width-1] && (act == half);
        mism_s    = !undecided && (decision != y_out);

        start = accept && (k == '0);
        // Any out-of-order index mid-case drops the case; collection resumes at the next k=0.
        take  = start || ((state == COLLECT) && accept && (k == exp_k));
        last  = take && (k == last_k);

        mism_nx  = (start ? 1'b0 : mism_acc) | mism_s;
        err_nx   = (start ? 1'b0 : err_acc) | (a_out != y_out);
        pred_nx  = (start ? '0 : pred_acc)  | ({{(n_out-1){1'b0}}, decision} << k);
        ideal_nx = (start ? '0 : ideal_acc) | ({{(n_out-1){1'b0}}, y_out} << k);

        state_nx = IDLE;
        if (last)
            state_nx = REPORT;
        else if (take)
            state_nx = COLLECT;

        case_done = (state == REPORT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            exp_k        <= '0;
            mism_acc     <= 1'b0;
            err_acc      <= 1'b0;
            pred_acc     <= '0;
            ideal_acc    <= '0;
            case_correct <= 1'b0;
            case_error   <= 1'b0;
            pred         <= '0;
            ideal        <= '0;
            num_cases    <= '0;
            total_errors <= '0;
        end else begin
            state <= state_nx;
            if (take) begin
                exp_k     <= k + iw'(1);
                mism_acc  <= mism_nx;
                err_acc   <= err_nx;
                pred_acc  <= pred_nx;
                ideal_acc <= ideal_nx;
            end
            if (last) begin
                case_correct <= !mism_nx;
                case_error   <= err_nx;
                pred         <= pred_nx;
                ideal        <= ideal_nx;
                num_cases    <= sat_inc(num_cases, 1'b1);
                total_errors <= sat_inc(total_errors, err_nx);
            end
        end
    end

    rolling_window_count #(
        .window (window)
    ) u_window (
        .clk    (clk),
        .reset  (reset),
        .en     (last),
        .bit_in (!mism_nx),
        .count  (recent_correct)
    );

endmodule

// File: tb/tb_dnn_output_scoreboard.sv
// Directed table-driven bench for dnn_output_scoreboard plus window, reset and sequence-break cases.
module tb_dnn_output_scoreboard;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [4:0]  cycle_index;
    logic [31:0] act;
    logic        a_out, y_out;
    logic        case_done, case_correct, case_error;
    logic [15:0] pred, ideal;
    logic [31:0] num_cases, total_errors;
    logic [6:0]  recent_correct;

    dnn_output_scoreboard dut (
        .clk            (clk),
        .reset          (reset),
        .cycle_index    (cycle_index),
        .act            (act),
        .a_out          (a_out),
        .y_out          (y_out),
        .case_done      (case_done),
        .case_correct   (case_correct),
        .case_error     (case_error),
        .pred           (pred),
        .ideal          (ideal),
        .num_cases      (num_cases),
        .total_errors   (total_errors),
        .recent_correct (recent_correct)
    );

    typedef struct packed {
        logic [15:0][31:0] acts;
        logic [15:0]       y;
        logic [15:0]       a;
        logic              corr;
        logic              err;
        logic [15:0]       pred;
    } vec_t;

    vec_t vecs [7];
    int   total_cnt = 0;
    int   pass_cnt  = 0;
    int   exp_num   = 0;
    int   exp_err   = 0;
    int   hist_q [$];
    logic seen_done;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [15:0][31:0] acts_from(input logic [15:0] y, input logic [31:0] hi,
                                                    input logic [31:0] lo);
        logic [15:0][31:0] r;
        for (int k = 0; k < 16; k++) r[k] = y[k] ? hi : lo;
        return r;
    endfunction

    function automatic int recent_sum();
        int s = 0;
        foreach (hist_q[i]) s += hist_q[i];
        return s;
    endfunction

    task automatic model_reset();
        exp_num = 0;
        exp_err = 0;
        hist_q.delete();
    endtask

    task automatic model_case(input logic corr, input logic err);
        exp_num++;
        exp_err += int'(err);
        hist_q.push_back(int'(corr));
        if (hist_q.size() > 100) void'(hist_q.pop_front());
    endtask

    task automatic tick(input int ci, input logic [31:0] a_act, input logic a_b, input logic y_b,
                        input logic rst);
        cycle_index = 5'(ci);
        act         = a_act;
        a_out       = a_b;
        y_out       = y_b;
        reset       = rst;
        @(posedge clk);
        #1;
        if (case_done) seen_done = 1'b1;
    endtask

    task automatic drive_block(input vec_t v);
        for (int ci = 0; ci < 18; ci++) begin
            if (ci >= 2) tick(ci, v.acts[ci-2], v.a[ci-2], v.y[ci-2], 1'b0);
            else         tick(ci, 32'h0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic check_case(input string tag, input vec_t v);
        chk({tag, " done"},    64'(case_done),      64'd1);
        chk({tag, " correct"}, 64'(case_correct),   64'(v.corr));
        chk({tag, " error"},   64'(case_error),     64'(v.err));
        chk({tag, " pred"},    64'(pred),           64'(v.pred));
        chk({tag, " ideal"},   64'(ideal),          64'(v.y));
        chk({tag, " num"},     64'(num_cases),      64'(exp_num));
        chk({tag, " errs"},    64'(total_errors),   64'(exp_err));
        chk({tag, " recent"},  64'(recent_correct), 64'(recent_sum()));
    endtask

    initial begin
        // y-driven acts: 1.0 where ideal is 1, 0.0 where ideal is 0
        vecs[0] = '{acts_from(16'hA5C3, 32'h0020_0000, 32'h0), 16'hA5C3, 16'hA5C3, 1'b1, 1'b0, 16'hA5C3};
        vecs[1] = '{acts_from(16'hFFFF, 32'h0020_0000, 32'h0), 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFDF};
        vecs[1].acts[5] = 32'hFFF0_0000;
        vecs[2] = '{acts_from(16'h0, 32'h0, 32'h0010_0000), 16'h3C5A, 16'h3C5A, 1'b1, 1'b0, 16'h0000};
        vecs[3] = '{acts_from(16'h0F0F, 32'h0020_0000, 32'h0), 16'h0F0F, 16'h8F0F, 1'b1, 1'b1, 16'h0F0F};
        vecs[4] = '{acts_from(16'h00FF, 32'h0010_0001, 32'h000F_FFFF), 16'h00FF, 16'h00FF, 1'b1, 1'b0, 16'h00FF};
        vecs[5] = '{acts_from(16'h8001, 32'h7FFF_FFFF, 32'h8000_0000), 16'h8001, 16'h8001, 1'b1, 1'b0, 16'h8001};
        vecs[6] = '{acts_from(16'h0, 32'h0, 32'h0), 16'h0001, 16'h0000, 1'b0, 1'b1, 16'h0000};

        seen_done = 1'b0;
        for (int i = 0; i < 3; i++) tick(0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("rst done",    64'(case_done),      64'd0);
        chk("rst correct", 64'(case_correct),   64'd0);
        chk("rst error",   64'(case_error),     64'd0);
        chk("rst pred",    64'(pred),           64'd0);
        chk("rst ideal",   64'(ideal),          64'd0);
        chk("rst num",     64'(num_cases),      64'd0);
        chk("rst errs",    64'(total_errors),   64'd0);
        chk("rst recent",  64'(recent_correct), 64'd0);

        for (int i = 0; i < 7; i++) begin
            drive_block(vecs[i]);
            model_case(vecs[i].corr, vecs[i].err);
            check_case($sformatf("vec%0d", i), vecs[i]);
            tick(0, 32'h0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("vec%0d done low", i), 64'(case_done), 64'd0);
            chk($sformatf("vec%0d pred hold", i), 64'(pred), 64'(vecs[i].pred));
        end

        // Index jumps 8 -> 12 mid-case: case dropped, nothing reported.
        seen_done = 1'b0;
        for (int ci = 0; ci < 18; ci++) begin
            if (ci >= 9 && ci <= 11) continue;
            tick(ci, ci >= 2 ? vecs[0].acts[ci-2] : 32'h0, 1'b0, 1'b0, 1'b0);
        end
        chk("jump no done", 64'(seen_done), 64'd0);
        chk("jump num",     64'(num_cases), 64'(exp_num));
        drive_block(vecs[0]);
        model_case(1'b1, 1'b0);
        check_case("after jump", vecs[0]);

        // Reset at cycle_index 9: rest of that block discarded.
        seen_done = 1'b0;
        for (int ci = 0; ci < 18; ci++)
            tick(ci, ci >= 2 ? vecs[0].acts[ci-2] : 32'h0, 1'b0, 1'b0, ci == 9);
        model_reset();
        chk("midrst no done", 64'(seen_done),      64'd0);
        chk("midrst num",     64'(num_cases),      64'd0);
        chk("midrst errs",    64'(total_errors),   64'd0);
        chk("midrst recent",  64'(recent_correct), 64'd0);
        drive_block(vecs[0]);
        model_case(1'b1, 1'b0);
        check_case("after midrst", vecs[0]);

        // Reset coinciding with the last sample wins.
        seen_done = 1'b0;
        for (int ci = 0; ci < 18; ci++)
            tick(ci, ci >= 2 ? vecs[0].acts[ci-2] : 32'h0, 1'b0, 1'b0, ci == 17);
        model_reset();
        chk("lastrst no done", 64'(seen_done), 64'd0);
        chk("lastrst num",     64'(num_cases), 64'd0);

        // Window: 105 correct cases, then one incorrect.
        for (int i = 1; i <= 105; i++) begin
            drive_block(vecs[0]);
            model_case(1'b1, 1'b0);
            chk($sformatf("win case%0d recent", i), 64'(recent_correct), 64'(recent_sum()));
            if (i == 100) chk("win recent at 100", 64'(recent_correct), 64'd100);
        end
        chk("win recent at 105", 64'(recent_correct), 64'd100);
        drive_block(vecs[1]);
        model_case(1'b0, 1'b0);
        check_case("win case106", vecs[1]);
        chk("win recent at 106", 64'(recent_correct), 64'd99);
        chk("win num at 106",    64'(num_cases),      64'd106);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
